// File: rtl/down_counter_ctrl.sv
// Down-counter with start/busy/done handshake, clock enable, abort and
// one-shot or auto-reload modes; also tallies completed passes (saturating).
module down_counter_ctrl #(
    parameter int WIDTH = 4,
    parameter int PW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic             reload,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic [PW-1:0]    pass_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    PASS_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]    PASS_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    PASS_MAX  = {PW{1'b1}};

    state_t           state_r,    state_s;
    logic [WIDTH-1:0] load_r,     load_s;
    logic [WIDTH-1:0] count_r,    count_s;
    logic             busy_r,     busy_s;
    logic             tc_r,       tc_s;
    logic             done_r,     done_s;
    logic [PW-1:0]    pass_cnt_r, pass_cnt_s;

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            load_r     <= CNT_ZERO;
            count_r    <= CNT_ZERO;
            busy_r     <= 1'b0;
            tc_r       <= 1'b0;
            done_r     <= 1'b0;
            pass_cnt_r <= PASS_ZERO;
        end else begin
            state_r    <= state_s;
            load_r     <= load_s;
            count_r    <= count_s;
            busy_r     <= busy_s;
            tc_r       <= tc_s;
            done_r     <= done_s;
            pass_cnt_r <= pass_cnt_s;
        end
    end

    // Next-state and next-output logic; tc/done default low so they pulse.
    always_comb begin
        state_s    = state_r;
        load_s     = load_r;
        count_s    = count_r;
        busy_s     = busy_r;
        tc_s       = 1'b0;
        done_s     = 1'b0;
        pass_cnt_s = pass_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    pass_cnt_s = PASS_ZERO;
                    if (n != CNT_ZERO) begin
                        load_s  = n;
                        count_s = n;
                        busy_s  = 1'b1;
                        state_s = ST_RUN;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    count_s = CNT_ZERO;
                end else if (!en) begin
                    // Frozen: the pulse already emitted for this pass is not repeated.
                    state_s = ST_RUN;
                end else if (count_r > CNT_ONE) begin
                    count_s = count_r - CNT_ONE;
                end else if (count_r == CNT_ONE) begin
                    count_s = CNT_ZERO;
                    tc_s    = 1'b1;
                    if (pass_cnt_r != PASS_MAX) begin
                        pass_cnt_s = pass_cnt_r + PASS_ONE;
                    end else begin
                        pass_cnt_s = PASS_MAX;
                    end
                end else if (reload) begin
                    count_s = load_r;
                end else begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                count_s = CNT_ZERO;
            end
        endcase
    end

    assign count    = count_r;
    assign busy     = busy_r;
    assign tc       = tc_r;
    assign done     = done_r;
    assign pass_cnt = pass_cnt_r;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Self-checking bench for down_counter_ctrl: directed scenarios plus random
// stimulus, all compared each cycle against a behavioural reference model.
module tb_down_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, reload, en, abort;
    logic [3:0] n;
    logic [3:0] count, count2;
    logic       busy, tc, done, busy2, tc2, done2;
    logic [7:0] pass_cnt;
    logic [1:0] pass_cnt2;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit m_run;
    int m_count, m_load, m_pass, m_pass2;
    bit m_tc, m_done;

    always #5 clk = ~clk;

    down_counter_ctrl #(.WIDTH(4), .PW(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .reload(reload),
        .en(en), .abort(abort), .count(count), .busy(busy), .tc(tc),
        .done(done), .pass_cnt(pass_cnt)
    );

    down_counter_ctrl #(.WIDTH(4), .PW(2)) u_dut_pw2 (
        .clk(clk), .rst(rst), .start(start), .n(n), .reload(reload),
        .en(en), .abort(abort), .count(count2), .busy(busy2), .tc(tc2),
        .done(done2), .pass_cnt(pass_cnt2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs as applied.
    task automatic model_step();
        m_tc   = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_count = 0; m_load = 0; m_pass = 0; m_pass2 = 0;
        end else if (!m_run) begin
            if (start && !abort) begin
                m_pass = 0; m_pass2 = 0;
                if (n != 0) begin
                    m_load = n; m_count = n; m_run = 1'b1;
                end else begin
                    m_done = 1'b1;
                end
            end
        end else if (abort) begin
            m_run = 1'b0; m_count = 0;
        end else if (!en) begin
            // stalled: nothing advances
        end else if (m_count >= 2) begin
            m_count = m_count - 1;
        end else if (m_count == 1) begin
            m_count = 0; m_tc = 1'b1;
            m_pass  = (m_pass  < 255) ? m_pass  + 1 : 255;
            m_pass2 = (m_pass2 < 3)   ? m_pass2 + 1 : 3;
        end else if (reload) begin
            m_count = m_load;
        end else begin
            m_run = 1'b0; m_done = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_val("count",     count,     m_count);
        check_val("busy",      busy,      m_run);
        check_val("tc",        tc,        m_tc);
        check_val("done",      done,      m_done);
        check_val("pass_cnt",  pass_cnt,  m_pass);
        check_val("pass_cnt2", pass_cnt2, m_pass2);
        check_val("busy2",     busy2,     m_run);
    endtask

    task automatic idle_in();
        rst = 1'b0; start = 1'b0; abort = 1'b0; en = 1'b1;
    endtask

    task automatic do_start(input int nv, input bit rl);
        start = 1'b1; n = 4'(nv); reload = rl;
        cyc();
        start = 1'b0; n = 4'($urandom_range(0, 15));
    endtask

    // Cycles from an accepted start until done, bounded.
    task automatic run_to_done(input int bound, output int lat);
        lat = 0;
        for (int i = 0; i < bound; i++) begin
            cyc();
            lat++;
            if (done) break;
        end
    endtask

    initial begin
        int lat;
        idle_in(); reload = 1'b0; n = 4'd5;
        m_run = 0; m_count = 0; m_load = 0; m_pass = 0; m_pass2 = 0;
        m_tc = 0; m_done = 0;

        // reset with start asserted
        rst = 1'b1; start = 1'b1;
        cyc(); cyc();
        idle_in();

        // one-shot n=3: done N+1 cycles after the start edge
        do_start(3, 1'b0);
        run_to_done(40, lat);
        check_val("lat_n3", lat, 4);
        cyc();

        // auto-reload n=2, then drop reload
        do_start(2, 1'b1);
        repeat (6) cyc();
        reload = 1'b0;
        run_to_done(40, lat);
        check_val("reload_drop_pass", pass_cnt, 3);

        // stall 3 cycles at count=2 for n=4
        start = 1'b1; n = 4'd4; reload = 1'b0;
        cyc();
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            en = !(i >= 3 && i <= 5);
            cyc();
            lat = i;
            if (done) break;
        end
        en = 1'b1;
        check_val("lat_stall", lat, 8);

        // stall at count=0 right after tc
        do_start(2, 1'b0);
        cyc(); cyc();
        en = 1'b0; cyc(); cyc(); cyc();
        en = 1'b1; cyc(); cyc();

        // abort at count=2, then start+abort in idle
        do_start(5, 1'b1);
        repeat (3) cyc();
        abort = 1'b1; cyc();
        abort = 1'b1; start = 1'b1; n = 4'd6; cyc();
        idle_in(); cyc();

        // start with a different n during RUN
        do_start(3, 1'b0);
        start = 1'b1; n = 4'd9; cyc();
        start = 1'b0;
        run_to_done(40, lat);
        check_val("lat_restart_ignored", lat, 3);

        // zero-length run
        do_start(0, 1'b0);
        check_val("zero_done", done, 1);
        cyc();

        // maximum load value: 16-cycle pass
        do_start(15, 1'b0);
        run_to_done(40, lat);
        check_val("lat_n15", lat, 16);

        // pass counter saturation on the PW=2 instance
        do_start(1, 1'b1);
        repeat (12) cyc();
        check_val("pw2_sat", pass_cnt2, 3);
        reload = 1'b0; run_to_done(10, lat);

        // reset mid-run at count=5 in reload mode, then normal start
        do_start(7, 1'b1);
        cyc(); cyc();
        rst = 1'b1; cyc();
        rst = 1'b0; reload = 1'b0;
        do_start(3, 1'b0);
        run_to_done(40, lat);
        check_val("lat_after_rst", lat, 4);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            abort  = ($urandom_range(0, 39) == 0);
            start  = ($urandom_range(0, 3) == 0);
            en     = ($urandom_range(0, 9) < 8);
            n      = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) reload = ~reload;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/down_counter_ctrl.md
# down_counter_ctrl

Parametrised down-counter with a start/busy/done handshake, a clock enable, abort, and one-shot or auto-reload modes. It replaces the fixed 4-bit free-loading down counter in the sum-of-N datapath. Each pass sequences exactly N+1 count states (N down to 0) for the accumulator controller. It also counts completed passes for multi-round operation.

## Interface
- WIDTH, 4, width of load value and count
- PW, 8, width of completed-pass counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a run; sampled only in IDLE
- n  in  WIDTH  load value; latched on accepted start
- reload  in  1  1 = auto-reload mode, 0 = one-shot; sampled when count is 0
- en  in  1  count enable; 0 freezes all RUN state
- abort  in  1  terminate run immediately; no done
- count  out  WIDTH  current count
- busy  out  1  high while in RUN
- tc  out  1  one-cycle pulse, high in the cycle count first shows 0 for a pass
- done  out  1  one-cycle pulse on normal one-shot completion
- pass_cnt  out  PW  passes reaching 0 since last accepted start; saturating

## Operation
- States: IDLE, RUN. All outputs are registered.
- Reset value of every output is 0: count, busy, tc, done, pass_cnt; state returns to IDLE. Reset overrides all other inputs.
- IDLE, start=1, abort=0, n≠0:
  - latch n into load_reg; count←n; busy←1; pass_cnt←0; go to RUN.
- IDLE, start=1, abort=0, n=0:
  - zero-length run: done←1 for one cycle; busy, tc and count stay 0; pass_cnt←0; stay in IDLE.
- IDLE, start=1 with abort=1: start is ignored.
- Outside RUN, abort has no effect.
- RUN, priority order: abort > en=0 > counting.
  - abort=1: state←IDLE, busy←0, count←0, tc←0, done←0; pass_cnt holds.
  - en=0: count, tc and state hold; tc is not re-pulsed.
  - count>1: count←count−1.
  - count=1: count←0, tc←1, pass_cnt←pass_cnt+1, saturating at 2^PW−1.
  - count=0, reload=1: count←load_reg and stay in RUN. tc drops.
  - count=0, reload=0: state←IDLE, busy←0, done←1, count stays 0.
- start while in RUN is ignored, and n changes have no effect until the next accepted start.
- Dropping reload mid-pass ends the run at the end of the current pass.
- tc and done are each high for exactly one cycle. An en=0 stall at count=0 extends neither.

## Timing
- Accepted start at edge k: count=n and busy=1 after edge k.
- With en held high and n=N≥1:
  - tc=1 after edge k+N;
  - done=1 and busy=0 after edge k+N+1;
  - start→done latency is N+1 cycles; each pass is N+1 cycles.
- Auto-reload: count sequence N…1,0,N…1,0…, with tc once per pass. There is no gap cycle between passes.
- Each en=0 cycle adds exactly one cycle of latency.
- Abort at edge j: busy=0 and count=0 after edge j.
- A new start is accepted in the cycle after done, i.e. back-to-back runs are allowed.
- Zero-length run: done=1 after the edge that accepts start.

## Test plan
- Reset and one-shot:
  - rst=1 for 2 cycles with start=1 → all outputs 0, state IDLE.
  - Then start with n=3, en=1, reload=0 → count 3,2,1,0; tc high with the first 0; next cycle done=1, busy=0; pass_cnt=1.
- Auto-reload with mode change:
  - n=2, reload=1, run 7 cycles → count 2,1,0,2,1,0,2; tc pulses twice; pass_cnt=2; done never asserted.
  - Drop reload → run ends after the next 0 with done=1.
- Enable stall:
  - n=4 with en=0 for 3 cycles while count=2 → count holds at 2; done arrives 3 cycles later than in the unstalled run (edge k+8).
  - Stall at count=0 → tc is still a single pulse.
- Abort and simultaneous events:
  - Abort at count=2 → busy=0, count=0 next cycle; done=0, tc=0.
  - start+abort together in IDLE → ignored.
  - start during RUN with a different n → run unaffected.
- Boundaries:
  - n=0 → done pulse next cycle, busy stays 0.
  - n=2^WIDTH−1 (15 at WIDTH=4) → 16-cycle pass.
  - PW=2 with 5 reload passes → pass_cnt saturates at 3.
- Reset mid-run: rst=1 at count=5 in reload mode → all outputs 0 next cycle; a following start behaves normally.
